mem_stage_lsu: RTL and testbench

//  Memory-stage load/store unit: producer of read_data_m_i for the MEM/WB register.

---
 rtl/mem_stage_lsu.sv | 89 ++++++++
 tb/tb_mem_stage_lsu.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-stage load/store unit driving a valid/ready dmem handshake and formatting load data
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
module mem_stage_lsu #(
  parameter int RSP_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid_m_i,
  input  logic                   mem_read_m_i,
  input  logic                   mem_write_m_i,
  input  logic [2:0]             funct3_m_i,
  input  logic [`DATA_WIDTH-1:0] alu_result_m_i,
  input  logic [`DATA_WIDTH-1:0] write_data_m_i,
  output logic                   stall_m_o,
  output logic [`DATA_WIDTH-1:0] read_data_m_o,
  output logic                   misaligned_o,
  output logic                   bus_err_o,
  output logic                   dmem_req_valid_o,
  input  logic                   dmem_req_ready_i,
  output logic                   dmem_req_we_o,
  output logic [`DATA_WIDTH-1:0] dmem_req_addr_o,
  output logic [3:0]             dmem_req_be_o,
  output logic [`DATA_WIDTH-1:0] dmem_req_wdata_o,
  input  logic                   dmem_rsp_valid_i,
  input  logic [`DATA_WIDTH-1:0] dmem_rsp_rdata_i
);
  localparam int DW = `DATA_WIDTH;
  localparam int CW = $clog2(RSP_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [DW-1:0] addr_q, wdata_q, wdata_d, shifted, fmt;
  logic [3:0] be_q, be_d;
  logic [2:0] f3_q;
  logic we_q, is_b, is_h, mis, start, acc, tmo;
  // bu/hu encodings are load-only; as store sizes they fall back to word
  always_comb begin
    is_b = funct3_m_i == 3'b000 || (!mem_write_m_i && funct3_m_i == 3'b100);
    is_h = funct3_m_i == 3'b001 || (!mem_write_m_i && funct3_m_i == 3'b101);
    mis = is_h ? alu_result_m_i[0] : !is_b && alu_result_m_i[1:0] != 2'b00;
    misaligned_o = valid_m_i && (mem_read_m_i || mem_write_m_i) && mis;
    start = valid_m_i && (mem_read_m_i || mem_write_m_i) && !mis;
    be_d = is_b ? 4'b0001 << alu_result_m_i[1:0] : is_h ? 4'b0011 << {alu_result_m_i[1], 1'b0} : 4'b1111;
    wdata_d = is_b ? {4{write_data_m_i[7:0]}} : is_h ? {2{write_data_m_i[15:0]}} : write_data_m_i;
    shifted = dmem_rsp_rdata_i >> {addr_q[1:0], 3'b000};
    fmt = f3_q == 3'b000 ? {{(DW-8){shifted[7]}}, shifted[7:0]} :
          f3_q == 3'b100 ? {{(DW-8){1'b0}}, shifted[7:0]} :
          f3_q == 3'b001 ? {{(DW-16){shifted[15]}}, shifted[15:0]} :
          f3_q == 3'b101 ? {{(DW-16){1'b0}}, shifted[15:0]} : shifted;
    acc = state == REQ && dmem_req_ready_i;
    tmo = state == RESP && !dmem_rsp_valid_i && cnt == CW'(RSP_TIMEOUT);
    state_nx = state == IDLE ? (start ? REQ : IDLE) :
               state == REQ  ? (acc ? (we_q ? DONE : RESP) : REQ) :
               state == RESP ? (dmem_rsp_valid_i || tmo ? DONE : RESP) : IDLE;
    stall_m_o = (state == IDLE && start) || state == REQ || state == RESP;
    dmem_req_valid_o = state == REQ;
  end
  assign dmem_req_we_o = we_q;
  assign dmem_req_addr_o = {addr_q[DW-1:2], 2'b00};
  assign dmem_req_be_o = be_q;
  assign dmem_req_wdata_o = wdata_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
      f3_q <= '0;
      we_q <= 1'b0;
      read_data_m_o <= '0;
      bus_err_o <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= state == RESP ? cnt + 1'b1 : '0;
      bus_err_o <= tmo;
      if (state == IDLE && start) begin
        addr_q <= alu_result_m_i;
        wdata_q <= wdata_d;
        be_q <= be_d;
        f3_q <= funct3_m_i;
        we_q <= mem_write_m_i;
      end
      if (state == RESP && (dmem_rsp_valid_i || tmo))
        read_data_m_o <= dmem_rsp_valid_i ? fmt : '0;
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: scoreboard bench for mem_stage_lsu covering loads, stores, misalignment, backpressure, timeout and reset
module tb_mem_stage_lsu;
  logic clk = 1'b0, rst_n = 1'b0;
  logic valid_m_i = 0, mem_read_m_i = 0, mem_write_m_i = 0;
  logic [2:0] funct3_m_i = 0;
  logic [31:0] alu_result_m_i = 0, write_data_m_i = 0, dmem_rsp_rdata_i = 0;
  logic dmem_req_ready_i = 0, dmem_rsp_valid_i = 0;
  logic stall_m_o, misaligned_o, bus_err_o, dmem_req_valid_o, dmem_req_we_o;
  logic [31:0] read_data_m_o, dmem_req_addr_o, dmem_req_wdata_o;
  logic [3:0] dmem_req_be_o;
  always #5 clk = ~clk;

  mem_stage_lsu dut (
    .clk(clk), .rst_n(rst_n), .valid_m_i(valid_m_i), .mem_read_m_i(mem_read_m_i),
    .mem_write_m_i(mem_write_m_i), .funct3_m_i(funct3_m_i), .alu_result_m_i(alu_result_m_i),
    .write_data_m_i(write_data_m_i), .stall_m_o(stall_m_o), .read_data_m_o(read_data_m_o),
    .misaligned_o(misaligned_o), .bus_err_o(bus_err_o), .dmem_req_valid_o(dmem_req_valid_o),
    .dmem_req_ready_i(dmem_req_ready_i), .dmem_req_we_o(dmem_req_we_o),
    .dmem_req_addr_o(dmem_req_addr_o), .dmem_req_be_o(dmem_req_be_o),
    .dmem_req_wdata_o(dmem_req_wdata_o), .dmem_rsp_valid_i(dmem_rsp_valid_i),
    .dmem_rsp_rdata_i(dmem_rsp_rdata_i)
  );

  int n_run = 0, n_fail = 0;
  typedef struct {
    logic [31:0] data;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] addr;
    int          stall;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  logic [31:0] o_data, o_addr, o_wdata;
  logic [3:0] o_be;
  logic o_we, o_berr, o_stable, o_stall0, o_to;
  int o_stall, o_req;

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    logic [7:0] b;
    logic [15:0] h;
    b = w[8*a[1:0] +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  // Runs one access to completion; rsp_dly is cycles after the accept cycle (<=0: never respond)
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rdata, input int rdy_dly, input int rsp_dly);
    int t, acc_t;
    logic seen;
    @(posedge clk); #1;
    valid_m_i = 1; mem_read_m_i = rd; mem_write_m_i = wr; funct3_m_i = f3;
    alu_result_m_i = a; write_data_m_i = wd; dmem_rsp_rdata_i = rdata;
    dmem_req_ready_i = 0; dmem_rsp_valid_i = 0;
    #1 o_stall0 = stall_m_o;
    o_stall = 0; o_req = 0; o_stable = 1; o_to = 0; o_berr = 0; o_data = 0;
    o_addr = 0; o_be = 0; o_wdata = 0; o_we = 0; acc_t = -1; seen = 0;
    for (t = 0; t < 400; t++) begin
      if (t > 0) begin
        @(posedge clk); #1;
        dmem_req_ready_i = dmem_req_valid_o && o_req >= rdy_dly;
        dmem_rsp_valid_i = acc_t >= 0 && rsp_dly > 0 && t == acc_t + rsp_dly;
      end
      @(negedge clk);
      if (stall_m_o) o_stall++;
      else if (t > 0) break;
      if (dmem_req_valid_o) begin
        if (!seen) begin
          o_addr = dmem_req_addr_o; o_be = dmem_req_be_o; o_wdata = dmem_req_wdata_o; o_we = dmem_req_we_o;
          seen = 1;
        end else if ({o_addr, o_be, o_wdata, o_we} !== {dmem_req_addr_o, dmem_req_be_o, dmem_req_wdata_o, dmem_req_we_o})
          o_stable = 0;
        if (dmem_req_ready_i) acc_t = t;
        o_req++;
      end
    end
    if (t == 400) o_to = 1;
    else begin
      o_data = read_data_m_o;
      o_berr = bus_err_o;
    end
    @(posedge clk); #1;
    valid_m_i = 0; mem_read_m_i = 0; mem_write_m_i = 0; dmem_req_ready_i = 0; dmem_rsp_valid_i = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_run++;
    if ({stall_m_o, misaligned_o, bus_err_o, dmem_req_valid_o, dmem_req_we_o, dmem_req_be_o} !== 9'h0) begin
      n_fail++; $display("FAIL reset_ctrl got %b exp 0", {stall_m_o, misaligned_o, bus_err_o, dmem_req_valid_o, dmem_req_we_o, dmem_req_be_o});
    end
    n_run++;
    if ({read_data_m_o, dmem_req_addr_o, dmem_req_wdata_o} !== 96'h0) begin
      n_fail++; $display("FAIL reset_data got %h %h %h exp 0", read_data_m_o, dmem_req_addr_o, dmem_req_wdata_o);
    end
    @(posedge clk); #1 rst_n = 1;
  endtask

  task automatic test_lw();
    sb.push_back('{32'hDEADBEEF, 1'b0, 4'b1111, 32'h0, 32'h100, 4});
    access(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 2);
    e = sb.pop_front();
    n_run++; if (o_to !== 1'b0) begin n_fail++; $display("FAIL lw_timeout got %b exp 0", o_to); end
    n_run++; if (o_data !== e.data) begin n_fail++; $display("FAIL lw_data got %h exp %h", o_data, e.data); end
    n_run++; if ({o_be, o_we, o_addr} !== {e.be, e.we, e.addr}) begin
      n_fail++; $display("FAIL lw_req got %b %b %h exp %b %b %h", o_be, o_we, o_addr, e.be, e.we, e.addr); end
    n_run++; if (o_stall !== e.stall || o_stall0 !== 1'b1) begin
      n_fail++; $display("FAIL lw_stall got %0d/%b exp %0d/1", o_stall, o_stall0, e.stall); end
  endtask

  task automatic test_load_fmt();
    logic [2:0] f3s [3] = '{3'b000, 3'b100, 3'b001};
    logic [31:0] ads [3] = '{32'h103, 32'h103, 32'h102};
    logic [31:0] exs [3] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF};
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{exs[i], 1'b0, 4'b0, 32'h0, 32'h0, 4});
      access(1, 0, f3s[i], ads[i], 32'h0, 32'h80FFFF7F, 0, 2);
      e = sb.pop_front();
      n_run++; if (o_data !== e.data || o_stall !== e.stall) begin
        n_fail++; $display("FAIL load_fmt%0d got %h/%0d exp %h/%0d", i, o_data, o_stall, e.data, e.stall); end
    end
  endtask

  task automatic test_store();
    logic [31:0] prev;
    prev = read_data_m_o;
    sb.push_back('{prev, 1'b1, 4'b1100, 32'hABCDABCD, 32'h100, 2});
    access(0, 1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 0, 0);
    e = sb.pop_front();
    n_run++; if ({o_we, o_be, o_wdata, o_addr} !== {e.we, e.be, e.wdata, e.addr}) begin
      n_fail++; $display("FAIL sh_req got %b %b %h %h exp %b %b %h %h", o_we, o_be, o_wdata, o_addr, e.we, e.be, e.wdata, e.addr); end
    n_run++; if (o_stall !== e.stall || o_to !== 1'b0) begin
      n_fail++; $display("FAIL sh_stall got %0d exp %0d", o_stall, e.stall); end
    n_run++; if (o_data !== e.data) begin n_fail++; $display("FAIL sh_hold got %h exp %h", o_data, e.data); end
  endtask

  task automatic test_misaligned();
    logic [2:0] f3s [2] = '{3'b010, 3'b001};
    logic [31:0] ads [2] = '{32'h101, 32'h101};
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      valid_m_i = 1; mem_read_m_i = (i == 0); mem_write_m_i = (i == 1); funct3_m_i = f3s[i]; alu_result_m_i = ads[i];
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        n_run++; if ({misaligned_o, dmem_req_valid_o, stall_m_o} !== 3'b100) begin
          n_fail++; $display("FAIL misaligned%0d got %b exp 100", i, {misaligned_o, dmem_req_valid_o, stall_m_o}); end
      end
      @(posedge clk); #1;
      valid_m_i = 0; mem_read_m_i = 0; mem_write_m_i = 0;
    end
  endtask

  task automatic test_backpressure();
    sb.push_back('{32'h0, 1'b1, 4'b1111, 32'h55AA1234, 32'h200, 7});
    access(0, 1, 3'b010, 32'h200, 32'h55AA1234, 32'h0, 5, 0);
    e = sb.pop_front();
    n_run++; if (o_stable !== 1'b1 || o_req !== 6) begin
      n_fail++; $display("FAIL sw_stable got %b/%0d exp 1/6", o_stable, o_req); end
    n_run++; if ({o_we, o_be, o_wdata, o_addr} !== {e.we, e.be, e.wdata, e.addr}) begin
      n_fail++; $display("FAIL sw_req got %b %b %h %h exp %b %b %h %h", o_we, o_be, o_wdata, o_addr, e.we, e.be, e.wdata, e.addr); end
    n_run++; if (o_stall !== e.stall) begin n_fail++; $display("FAIL sw_stall got %0d exp %0d", o_stall, e.stall); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] f3s [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [2:0] f3;
    logic [31:0] a, w;
    int rdy, rsp;
    for (int i = 0; i < 8; i++) begin
      f3 = f3s[$urandom_range(0, 4)];
      a = 32'h400 + $urandom_range(0, 255);
      if (f3[1:0] == 2'b01) a[0] = 1'b0;
      if (f3 == 3'b010) a[1:0] = 2'b00;
      w = $urandom;
      rdy = $urandom_range(0, 2);
      rsp = $urandom_range(1, 3);
      sb.push_back('{exp_load(f3, a, w), 1'b0, 4'b0, 32'h0, {a[31:2], 2'b00}, 2 + rdy + rsp});
      access(1, 0, f3, a, 32'h0, w, rdy, rsp);
      e = sb.pop_front();
      n_run++; if (o_data !== e.data || o_stall !== e.stall || o_addr !== e.addr) begin
        n_fail++; $display("FAIL b2b%0d f3=%b a=%h got %h/%0d/%h exp %h/%0d/%h", i, f3, a, o_data, o_stall, o_addr, e.data, e.stall, e.addr); end
    end
  endtask

  task automatic test_timeout();
    access(1, 0, 3'b010, 32'h300, 32'h0, 32'h12345678, 0, 0);
    n_run++; if (o_to !== 1'b0 || o_berr !== 1'b1 || o_data !== 32'h0) begin
      n_fail++; $display("FAIL timeout_err got to=%b err=%b data=%h exp 0/1/0", o_to, o_berr, o_data); end
    n_run++; if (o_stall < 257 || o_stall > 258) begin
      n_fail++; $display("FAIL timeout_len got %0d exp 257..258", o_stall); end
    @(negedge clk);
    n_run++; if (bus_err_o !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse got %b exp 0", bus_err_o); end
  endtask

  task automatic test_reset_mid();
    access(1, 0, 3'b010, 32'h104, 32'h0, 32'h11223344, 0, 1);
    n_run++; if (o_data !== 32'h11223344) begin n_fail++; $display("FAIL pre_rst got %h exp 11223344", o_data); end
    @(posedge clk); #1;
    valid_m_i = 1; mem_read_m_i = 1; funct3_m_i = 3'b010; alu_result_m_i = 32'h108; dmem_rsp_rdata_i = 32'hCAFEF00D;
    @(posedge clk); #1 dmem_req_ready_i = 1;
    @(posedge clk); #1 dmem_req_ready_i = 0;
    repeat (4) @(posedge clk);
    #1 rst_n = 0; valid_m_i = 0; mem_read_m_i = 0;
    #2;
    n_run++; if ({stall_m_o, dmem_req_valid_o, bus_err_o, misaligned_o, read_data_m_o, dmem_req_addr_o} !== 68'h0) begin
      n_fail++; $display("FAIL rst_mid got %b %b %b %b %h %h exp 0", stall_m_o, dmem_req_valid_o, bus_err_o, misaligned_o, read_data_m_o, dmem_req_addr_o); end
    @(posedge clk); #1 rst_n = 1; dmem_rsp_valid_i = 1;
    @(posedge clk); #1 dmem_rsp_valid_i = 0;
    @(negedge clk);
    n_run++; if (read_data_m_o !== 32'h0 || stall_m_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_discard got %h/%b exp 0/0", read_data_m_o, stall_m_o); end
    sb.push_back('{32'hA5A5C3C3, 1'b0, 4'b1111, 32'h0, 32'h10C, 4});
    access(1, 0, 3'b010, 32'h10C, 32'h0, 32'hA5A5C3C3, 0, 2);
    e = sb.pop_front();
    n_run++; if (o_data !== e.data || o_stall !== e.stall || o_addr !== e.addr) begin
      n_fail++; $display("FAIL post_rst got %h/%0d/%h exp %h/%0d/%h", o_data, o_stall, o_addr, e.data, e.stall, e.addr); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_fmt();
    test_store();
    test_misaligned();
    test_backpressure();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
